logic_op_arbiter: RTL and testbench
===================================

Name: logic_op_arbiter

Overview:
Shares one combinational 4-bit logic unit (OR/AND/XOR/NAND) among NREQ requesters using round-robin arbitration. Each requester presents operands and an opcode with a request. The arbiter grants one requester per cycle and registers the result into a single-entry output buffer with valid/ready backpressure. It sits between the client blocks and the shared logic datapath and is the only driver of that datapath.

Parameters:
WIDTH, 4, operand/result width in bits
NREQ, 4, number of requesters (2..8)
IDW, $clog2(NREQ), width of requester index

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NREQ  per-requester request, level; bit i = requester i
op_a  input  NREQ*WIDTH  flat operand A; slice i = [i*WIDTH +: WIDTH]
op_b  input  NREQ*WIDTH  flat operand B, same slicing
op_sel  input  NREQ*2  flat opcode, slice i = [i*2 +: 2]
gnt  output  NREQ  one-hot grant; operands of granted requester are sampled at this edge
res_valid  output  1  result buffer holds a result
res_ready  input  1  consumer accepts result when res_valid & res_ready
res_data  output  WIDTH  registered result
res_id  output  IDW  index of requester that produced res_data
op_count  output  8  number of completed grants, wraps 255->0

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Reset: res_valid=0, res_data=0, res_id=0, op_count=0, rr pointer=0, FSM=EMPTY. gnt is combinational and therefore reads 0 while reset is asserted.
- Opcodes: 2'b00 OR, 2'b01 AND, 2'b10 XOR, 2'b11 NAND (bitwise ~(a&b)). All are WIDTH-bit with no carry.
- can_issue = (state==EMPTY) | res_ready.
- gnt is combinational: when can_issue & |req, gnt is one-hot on the first set req bit scanning from the rr pointer upward, wrapping modulo NREQ. Otherwise gnt=0.
- On a clock edge with gnt[i]=1:
  - res_data <= logic(op_a[i], op_b[i], op_sel[i]).
  - res_id <= i.
  - res_valid <= 1.
  - rr pointer <= (i+1) mod NREQ.
  - op_count <= op_count+1.
- Latency: a request that is granted in cycle N produces its result with res_valid=1 in cycle N+1.
- Requester rule: hold req and operands stable until gnt is seen. Deassert req, or present the next operation, in the cycle after gnt. A req that is dropped before grant is simply lost; it is not an error.
- FSM (2 states):
  - EMPTY: |req -> grant, go to FULL. Otherwise stay.
  - FULL, res_ready=0: gnt=0, hold res_* unchanged, stay.
  - FULL, res_ready=1 and |req: the accepted result is replaced in the same cycle (full throughput, 1 op/cycle). Stay FULL.
  - FULL, res_ready=1 and no req: res_valid <= 0, go to EMPTY. res_data and res_id keep their last value.
- Simultaneous requests: exactly one grant per cycle, in round-robin order. With all req bits held high, grants cycle 0,1,2,3,0,...
- res_ready while EMPTY: ignored.
- Reset mid-operation: the pending result is discarded, the pointer returns to 0, and no grant is issued during reset.
- Pointer wrap: a grant to requester NREQ-1 sets the pointer to 0.

Decomposition:
- Package logic_op_pkg holds:
  - opcode localparams OP_OR, OP_AND, OP_XOR, OP_NAND.
  - FSM state encoding ST_EMPTY, ST_FULL.
- Sub-module logic_unit (combinational, WIDTH param; a, b, sel -> y): the shared datapath, instantiated once after the operand mux.
- The arbiter contains the round-robin priority logic, the operand mux, the FSM, the result register and the counter.

Test Plan:
- Reset: assert rst_n=0 mid-stream with res_valid=1 -> res_valid=0, res_data=0, op_count=0, gnt=0 immediately. After release, requester 0 has highest priority.
- Single requester: req=4'b0001, a=2, b=5, sel=OR, res_ready=1 -> gnt=0001. Next cycle res_valid=1, res_data=4'b0111, res_id=0. With req dropped, res_valid falls the following cycle.
- Opcodes: requester 2 with a=6, b=5 over sel=0..3 -> results 0111, 0100, 0011, 1011, each tagged res_id=2.
- Round-robin: req=4'b1111 held, res_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, op_count increments by 1 per cycle, one result per cycle.
- Backpressure: req=4'b0110, res_ready=0 after the first result -> exactly one grant (to 1), then gnt=0 and res_data held. Raising res_ready -> next grant goes to 2 in that same cycle.
- Counter wrap: 256 back-to-back grants -> op_count returns to 0.

Source files
------------

// File: rtl/logic_op_pkg.sv
// Shared definitions for the round-robin logic-op arbiter slice.
package logic_op_pkg;

    // Opcode encodings for the shared logic unit
    localparam logic [1:0] OP_OR   = 2'b00;
    localparam logic [1:0] OP_AND  = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    // Result buffer occupancy
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/logic_unit.sv
// Shared combinational 4-function bitwise logic datapath.
module logic_unit
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);

    // Select the bitwise function named by the opcode
    always_comb begin
        y = '0;
        case (sel)
            OP_OR:   y = a | b;
            OP_AND:  y = a & b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one logic unit among NREQ requesters,
// with a single-entry valid/ready result buffer.
module logic_op_arbiter
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] op_a,
    input  logic [NREQ*WIDTH-1:0] op_b,
    input  logic [NREQ*2-1:0]     op_sel,
    output logic [NREQ-1:0]       gnt,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_data,
    output logic [IDW-1:0]        res_id,
    output logic [7:0]            op_count
);

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   gnt_idx;
    logic             can_issue;
    logic             issue;
    logic [WIDTH-1:0] mux_a;
    logic [WIDTH-1:0] mux_b;
    logic [1:0]       mux_sel;
    logic [WIDTH-1:0] lu_y;

    // Gating with rst_n keeps gnt low while reset is held
    assign can_issue = rst_n & ((state == ST_EMPTY) | res_ready);
    assign issue     = |gnt;

    // Round-robin scan from rr_ptr upward, wrapping modulo NREQ
    always_comb begin
        int unsigned    cand;
        logic [IDW-1:0] cand_idx;
        logic           found;
        gnt      = '0;
        gnt_idx  = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        if (can_issue) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                cand     = (int'(rr_ptr) + k) % NREQ;
                cand_idx = cand[IDW-1:0];
                if (!found && req[cand_idx]) begin
                    found         = 1'b1;
                    gnt[cand_idx] = 1'b1;
                    gnt_idx       = cand_idx;
                end
            end
        end
    end

    // Operand mux feeding the single shared datapath
    always_comb begin
        mux_a   = op_a[gnt_idx*WIDTH +: WIDTH];
        mux_b   = op_b[gnt_idx*WIDTH +: WIDTH];
        mux_sel = op_sel[gnt_idx*2 +: 2];
    end

    logic_unit #(
        .WIDTH (WIDTH)
    ) u_logic_unit (
        .a   (mux_a),
        .b   (mux_b),
        .sel (mux_sel),
        .y   (lu_y)
    );

    // Buffer FSM, result register, rr pointer and grant counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            rr_ptr    <= '0;
            op_count  <= '0;
        end else begin
            if (issue) begin
                res_data  <= lu_y;
                res_id    <= gnt_idx;
                res_valid <= 1'b1;
                rr_ptr    <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                op_count  <= op_count + 8'd1;
                state     <= ST_FULL;
            end else if (state == ST_FULL && res_ready) begin
                res_valid <= 1'b0;
                state     <= ST_EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed self-checking bench for logic_op_arbiter.
module tb_logic_op_arbiter;

    localparam int WIDTH = 4;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] op_a;
    logic [NREQ*WIDTH-1:0] op_b;
    logic [NREQ*2-1:0]     op_sel;
    logic [NREQ-1:0]       gnt;
    logic                  res_valid;
    logic                  res_ready;
    logic [WIDTH-1:0]      res_data;
    logic [IDW-1:0]        res_id;
    logic [7:0]            op_count;

    int n_vec;
    int n_err;

    logic_op_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ),
        .IDW   (IDW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sel    (op_sel),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] rr_data [4];
    logic [3:0] op_res  [4];

    initial begin
        n_vec = 0;
        n_err = 0;
        rr_data = '{4'hE, 4'hD, 4'hC, 4'hB};
        op_res  = '{4'h7, 4'h4, 4'h3, 4'hB};
        rst_n     = 1'b0;
        req       = '0;
        res_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_sel    = '0;

        // Power-on reset
        #12;
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_data",  32'(res_data),  32'd0);
        chk("rst_id",    32'(res_id),    32'd0);
        chk("rst_count", 32'(op_count),  32'd0);
        chk("rst_gnt",   32'(gnt),       32'd0);
        rst_n = 1'b1;
        tick();

        // Single requester, OR
        req = 4'b0001;
        op_a[0 +: 4] = 4'd2;
        op_b[0 +: 4] = 4'd5;
        op_sel[0 +: 2] = 2'b00;
        res_ready = 1'b1;
        #1;
        chk("single_gnt", 32'(gnt), 32'b0001);
        tick();
        chk("single_valid", 32'(res_valid), 32'd1);
        chk("single_data",  32'(res_data),  32'h7);
        chk("single_id",    32'(res_id),    32'd0);
        chk("single_count", 32'(op_count),  32'd1);
        req = '0;
        #1;
        chk("single_gnt_off", 32'(gnt), 32'd0);
        tick();
        chk("single_drain", 32'(res_valid), 32'd0);
        chk("single_hold",  32'(res_data),  32'h7);

        // All four opcodes on requester 2
        op_a[8 +: 4] = 4'd6;
        op_b[8 +: 4] = 4'd5;
        req = 4'b0100;
        for (int unsigned s = 0; s < 4; s++) begin
            op_sel[4 +: 2] = 2'(s);
            #1;
            chk("op_gnt", 32'(gnt), 32'b0100);
            tick();
            chk("op_data",  32'(res_data),  32'(op_res[s]));
            chk("op_id",    32'(res_id),    32'd2);
            chk("op_valid", 32'(res_valid), 32'd1);
        end
        chk("op_count", 32'(op_count), 32'd5);

        // Reset while a result is pending
        req = '0;
        res_ready = 1'b0;
        tick();
        chk("pre_rst_valid", 32'(res_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            op_a[i*4 +: 4] = 4'(i + 1);
            op_b[i*4 +: 4] = 4'hF;
            op_sel[i*2 +: 2] = 2'b10;
        end
        req = 4'b1111;
        res_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_data",  32'(res_data),  32'd0);
        chk("mid_rst_count", 32'(op_count),  32'd0);
        chk("mid_rst_gnt",   32'(gnt),       32'd0);
        #2;
        rst_n = 1'b1;
        #1;

        // Round-robin with all requesters active
        for (int k = 0; k < 5; k++) begin
            chk("rr_gnt", 32'(gnt), 32'(4'b0001 << (k % 4)));
            tick();
            chk("rr_id",    32'(res_id),    32'(k % 4));
            chk("rr_data",  32'(res_data),  32'(rr_data[k % 4]));
            chk("rr_count", 32'(op_count),  32'(k + 1));
            chk("rr_valid", 32'(res_valid), 32'd1);
        end
        req = '0;
        tick();
        chk("rr_drain", 32'(res_valid), 32'd0);

        // Backpressure: one grant, hold, then resume at requester 2
        req = 4'b0110;
        res_ready = 1'b0;
        #1;
        chk("bp_gnt1", 32'(gnt), 32'b0010);
        tick();
        chk("bp_id1",   32'(res_id),   32'd1);
        chk("bp_data1", 32'(res_data), 32'hD);
        for (int c = 0; c < 2; c++) begin
            chk("bp_gnt_stall", 32'(gnt), 32'd0);
            tick();
            chk("bp_hold_data",  32'(res_data),  32'hD);
            chk("bp_hold_id",    32'(res_id),    32'd1);
            chk("bp_hold_valid", 32'(res_valid), 32'd1);
            chk("bp_hold_count", 32'(op_count),  32'd6);
        end
        res_ready = 1'b1;
        #1;
        chk("bp_gnt2", 32'(gnt), 32'b0100);
        tick();
        chk("bp_id2",    32'(res_id),   32'd2);
        chk("bp_data2",  32'(res_data), 32'hC);
        chk("bp_count2", 32'(op_count), 32'd7);
        req = '0;
        tick();
        chk("bp_drain", 32'(res_valid), 32'd0);

        // Counter wrap
        req = 4'b1111;
        repeat (248) tick();
        chk("wrap_255", 32'(op_count), 32'd255);
        tick();
        chk("wrap_0",   32'(op_count), 32'd0);
        req = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
